// File: rtl/fft_twiddle_addr_gen_pkg.sv
// Shared constants, FSM state type and twiddle address map for the
// radix-2 DIT twiddle address sequencer.
package fft_pkg;

   localparam int LOG2N  = 5;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 16;
   localparam int STG_W  = $clog2(LOG2N);
   localparam int BF_W   = LOG2N - 1;

   // Counter values of the last twiddle in a frame.
   localparam logic [STG_W-1:0] LAST_STG = STG_W'(LOG2N - 1);
   localparam logic [BF_W-1:0]  LAST_BF  = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Stage s owns ROM entries (2^s - 1) .. (2^(s+1) - 2); butterfly j uses
   // entry k = j mod 2^s within that block.
   function automatic logic [ADDR_W-1:0] tw_addr(input logic [STG_W-1:0] stage,
                                                  input logic [BF_W-1:0]  bf);
      logic [ADDR_W-1:0] base;
      base = ADDR_W'((32'd1 << stage) - 32'd1);
      return base + (ADDR_W'(bf) & base);
   endfunction

endpackage

// File: rtl/fft_twiddle_addr_gen_if.sv
// Twiddle stream toward the butterfly engine.
// Handshake: a word transfers on every rising edge where tw_valid && tw_ready.
// Once tw_valid is high, tw_data and the tags hold until that transfer;
// tw_valid never depends combinationally on tw_ready.
interface fft_twiddle_addr_gen_if
   import fft_pkg::*;
   ;
   logic [DATA_W-1:0] tw_data;
   logic              tw_valid;
   logic              tw_ready;
   logic [STG_W-1:0]  tw_stage;
   logic [BF_W-1:0]   tw_bf;
   logic              tw_last;

   modport master (output tw_data, tw_valid, tw_stage, tw_bf, tw_last,
                   input  tw_ready);
   modport slave  (input  tw_data, tw_valid, tw_stage, tw_bf, tw_last,
                   output tw_ready);
endinterface

// File: rtl/fft_twiddle_addr_gen_skid.sv
// Output stage: holds tw_valid, the tags and the address of the presented
// word. ROM data passes straight through because the ROM re-reads the held
// address while stalled.
module fft_tw_skid
   import fft_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue,
   input  logic              flush,
   input  logic [STG_W-1:0]  in_stage,
   input  logic [BF_W-1:0]   in_bf,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic              in_last,
   input  logic [DATA_W-1:0] rom_data,
   output logic [ADDR_W-1:0] addr_q,
   output logic              handoff,
   fft_twiddle_addr_gen_if.master tw
);

   assign tw.tw_data = rom_data;
   assign handoff    = tw.tw_valid && tw.tw_ready;

   // Capture tags on issue, drop valid on handoff, clear valid on flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tw.tw_valid <= 1'b0;
         tw.tw_stage <= '0;
         tw.tw_bf    <= '0;
         tw.tw_last  <= 1'b0;
         addr_q      <= '0;
      end else if (flush) begin
         tw.tw_valid <= 1'b0;
      end else if (issue) begin
         tw.tw_valid <= 1'b1;
         tw.tw_stage <= in_stage;
         tw.tw_bf    <= in_bf;
         tw.tw_last  <= in_last;
         addr_q      <= in_addr;
      end else if (handoff) begin
         tw.tw_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fft_twiddle_addr_gen.sv
// Twiddle ROM address sequencer: walks every butterfly of every stage,
// drives the ROM address and presents the realigned ROM word with tags.
module fft_twiddle_addr_gen
   import fft_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   fft_twiddle_addr_gen_if.master tw,
   output state_t            dbg_state
);

   state_t            state;
   logic [STG_W-1:0]  stage_cnt;
   logic [BF_W-1:0]   bf_cnt;
   logic [ADDR_W-1:0] cur_addr;
   logic [ADDR_W-1:0] addr_q;
   logic              is_final;
   logic              issue;
   logic              handoff;

   assign is_final  = (stage_cnt == LAST_STG) && (bf_cnt == LAST_BF);
   assign cur_addr  = tw_addr(stage_cnt, bf_cnt);
   // A new word may be fetched when the output slot is empty or draining now.
   assign issue     = (state == RUN) && !abort && (!tw.tw_valid || tw.tw_ready);
   // When not issuing, re-read the presented word so rom_data stays put.
   assign rom_addr  = issue ? cur_addr : addr_q;
   assign busy      = (state == RUN) || (state == DRAIN);
   assign dbg_state = state;

   // Sequencer FSM with stage/butterfly counters and registered done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         stage_cnt <= '0;
         bf_cnt    <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            state     <= IDLE;
            stage_cnt <= '0;
            bf_cnt    <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) state <= RUN;
               end
               RUN: begin
                  if (issue) begin
                     if (is_final) begin
                        state     <= DRAIN;
                        stage_cnt <= '0;
                        bf_cnt    <= '0;
                     end else begin
                        bf_cnt <= bf_cnt + 1'b1;
                        if (bf_cnt == LAST_BF) stage_cnt <= stage_cnt + 1'b1;
                     end
                  end
               end
               DRAIN: begin
                  if (handoff && tw.tw_last) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   fft_tw_skid u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .issue    (issue),
      .flush    (abort),
      .in_stage (stage_cnt),
      .in_bf    (bf_cnt),
      .in_addr  (cur_addr),
      .in_last  (is_final),
      .rom_data (rom_data),
      .addr_q   (addr_q),
      .handoff  (handoff),
      .tw       (tw)
   );

endmodule
